// File: rtl/watch_pkg.sv
// Shared stopwatch definitions: field widths, field limits and the
// time-of-day record passed between the counter, converter and formatter.
package watch_pkg;
  localparam int MS_W     = 10;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HR_W_DEF = 4;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [HR_W_DEF-1:0] hr;
    logic [MIN_W-1:0]    min;
    logic [SEC_W-1:0]    s;
    logic [MS_W-1:0]     ms;
  } watch_time_t;
endpackage

// File: rtl/watch_counter_if.sv
// Control, preset, time and lap bundle between the stopwatch controller
// (master) and the watch_counter time base (slave).
interface watch_counter_if #(parameter int HR_WIDTH = 4);
  import watch_pkg::*;

  logic                enable;
  logic                mode;
  logic                load;
  logic [MS_W-1:0]     load_ms;
  logic [SEC_W-1:0]    load_s;
  logic [MIN_W-1:0]    load_min;
  logic [HR_WIDTH-1:0] load_hr;
  logic                lap;

  logic [MS_W-1:0]     ms;
  logic [SEC_W-1:0]    s;
  logic [MIN_W-1:0]    min;
  logic [HR_WIDTH-1:0] hr;
  logic [MS_W-1:0]     lap_ms;
  logic [SEC_W-1:0]    lap_s;
  logic [MIN_W-1:0]    lap_min;
  logic [HR_WIDTH-1:0] lap_hr;
  logic                lap_valid;
  logic                tick;
  logic                wrap;
  logic                expired;

  modport master (
    output enable, mode, load, load_ms, load_s, load_min, load_hr, lap,
    input  ms, s, min, hr, lap_ms, lap_s, lap_min, lap_hr,
           lap_valid, tick, wrap, expired
  );

  modport slave (
    input  enable, mode, load, load_ms, load_s, load_min, load_hr, lap,
    output ms, s, min, hr, lap_ms, lap_s, lap_min, lap_hr,
           lap_valid, tick, wrap, expired
  );
endinterface

// File: rtl/watch_digit_cnt.sv
// One time field: modulus MAX+1 up/down counter with saturating preset.
// Carry/borrow out are combinational from the current value so fields can
// be chained and all step on the same edge.
module watch_digit_cnt #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] val_o,
  output logic         co_o,
  output logic         bo_o
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] val_q, val_d;

  // Next value: preset (saturated) wins over stepping.
  always_comb begin
    val_d = val_q;
    if (load_i)     val_d = (load_val_i > MAXV) ? MAXV : load_val_i;
    else if (inc_i) val_d = (val_q == MAXV) ? '0 : val_q + 1'b1;
    else if (dec_i) val_d = (val_q == '0) ? MAXV : val_q - 1'b1;
  end

  // Field register.
  always_ff @(posedge clk) begin
    if (reset) val_q <= '0;
    else       val_q <= val_d;
  end

  assign val_o = val_q;
  assign co_o  = inc_i && (val_q == MAXV);
  assign bo_o  = dec_i && (val_q == '0);
endmodule

// File: rtl/watch_counter.sv
// Stopwatch/timer time base: 1 ms prescaler feeding four chained field
// counters (ms, s, min, hr), with preset load, lap capture, wrap and expiry.
module watch_counter
  import watch_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int HR_WIDTH = 4,
  parameter int HR_LIMIT = 10
) (
  input  logic            clk,
  input  logic            reset,
  watch_counter_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_fire, upd, inc_ms, dec_ms, uflow, ld;
  logic                co_ms, bo_ms, co_s, bo_s, co_min, bo_min, co_hr;
  logic [MS_W-1:0]     ms_w, ld_ms;
  logic [SEC_W-1:0]    s_w, ld_s;
  logic [MIN_W-1:0]    min_w, ld_min;
  logic [HR_WIDTH-1:0] hr_w, ld_hr;
  logic [MS_W-1:0]     lap_ms_q;
  logic [SEC_W-1:0]    lap_s_q;
  logic [MIN_W-1:0]    lap_min_q;
  logic [HR_WIDTH-1:0] lap_hr_q;
  logic                tick_q, wrap_q, expired_q, lap_valid_q;

  assign tick_fire = bus.enable && (presc_q == PRESC_LAST);
  // A tick landing on a load cycle is dropped.
  assign upd       = tick_fire && !bus.load;
  assign inc_ms    = upd && !bus.mode;
  // Once expired, down ticks are ignored until a load or reset.
  assign dec_ms    = upd && bus.mode && !expired_q;
  // Borrow out of the hour field means every field was zero: instead of
  // rolling under, reload zeros and flag expiry.
  assign uflow     = dec_ms && (hr_w == '0) && bo_ms && bo_s && bo_min;
  assign ld        = bus.load || uflow;
  assign ld_ms     = bus.load ? bus.load_ms  : '0;
  assign ld_s      = bus.load ? bus.load_s   : '0;
  assign ld_min    = bus.load ? bus.load_min : '0;
  assign ld_hr     = bus.load ? bus.load_hr  : '0;

  watch_digit_cnt #(.W(MS_W), .MAX(MS_MAX)) u_ms (
    .clk(clk), .reset(reset), .inc_i(inc_ms), .dec_i(dec_ms), .load_i(ld),
    .load_val_i(ld_ms), .val_o(ms_w), .co_o(co_ms), .bo_o(bo_ms));

  watch_digit_cnt #(.W(SEC_W), .MAX(SEC_MAX)) u_s (
    .clk(clk), .reset(reset), .inc_i(co_ms), .dec_i(bo_ms), .load_i(ld),
    .load_val_i(ld_s), .val_o(s_w), .co_o(co_s), .bo_o(bo_s));

  watch_digit_cnt #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc_i(co_s), .dec_i(bo_s), .load_i(ld),
    .load_val_i(ld_min), .val_o(min_w), .co_o(co_min), .bo_o(bo_min));

  logic bo_hr;
  watch_digit_cnt #(.W(HR_WIDTH), .MAX(HR_LIMIT - 1)) u_hr (
    .clk(clk), .reset(reset), .inc_i(co_min), .dec_i(bo_min), .load_i(ld),
    .load_val_i(ld_hr), .val_o(hr_w), .co_o(co_hr), .bo_o(bo_hr));

  // Prescaler next state: load restarts the ms period, enable=0 freezes it.
  always_comb begin
    presc_d = presc_q;
    if (bus.load)        presc_d = '0;
    else if (bus.enable) presc_d = tick_fire ? '0 : presc_q + 1'b1;
  end

  // Prescaler, status pulses, expiry and lap capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      expired_q   <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_ms_q    <= '0;
      lap_s_q     <= '0;
      lap_min_q   <= '0;
      lap_hr_q    <= '0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= upd;
      wrap_q      <= inc_ms && co_hr;
      if (bus.load)   expired_q <= 1'b0;
      else if (bo_hr) expired_q <= 1'b1;
      lap_valid_q <= bus.lap;
      if (bus.lap) begin
        lap_ms_q  <= ms_w;
        lap_s_q   <= s_w;
        lap_min_q <= min_w;
        lap_hr_q  <= hr_w;
      end
    end
  end

  assign bus.ms        = ms_w;
  assign bus.s         = s_w;
  assign bus.min       = min_w;
  assign bus.hr        = hr_w;
  assign bus.lap_ms    = lap_ms_q;
  assign bus.lap_s     = lap_s_q;
  assign bus.lap_min   = lap_min_q;
  assign bus.lap_hr    = lap_hr_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.expired   = expired_q;
endmodule

// File: tb/tb_watch_counter.sv
// Bench for watch_counter: directed test-plan steps plus a randomized phase,
// each cycle checked against a model that keeps time as a single ms total.
module tb_watch_counter;
  localparam int TD   = 4;
  localparam int HW   = 4;
  localparam int HL   = 10;
  localparam int MAXT = HL * 3600000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  watch_counter_if #(.HR_WIDTH(HW)) bus ();
  watch_counter #(.TICK_DIV(TD), .HR_WIDTH(HW), .HR_LIMIT(HL)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0, failures = 0;
  int m_tot = 0, m_pre = 0, m_lap = 0;
  bit m_exp = 0, m_lapv = 0, m_tick = 0, m_wrap = 0;

  function automatic logic [25:0] enc(int h, int mi, int s, int ms);
    return {HW'(h), 6'(mi), 6'(s), 10'(ms)};
  endfunction

  function automatic logic [25:0] enc_tot(int t);
    return enc(t / 3600000, (t / 60000) % 60, (t / 1000) % 60, t % 1000);
  endfunction

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic cyc();
    bit fire;
    if (reset) begin
      m_tot = 0; m_pre = 0; m_lap = 0;
      m_exp = 0; m_lapv = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_lapv = bus.lap;
      if (bus.lap) m_lap = m_tot;
      fire   = bus.enable && (m_pre == TD - 1);
      m_tick = 0;
      m_wrap = 0;
      if (bus.load) begin
        m_tot = clampi(int'(bus.load_hr), HL - 1) * 3600000
              + clampi(int'(bus.load_min), 59) * 60000
              + clampi(int'(bus.load_s), 59) * 1000
              + clampi(int'(bus.load_ms), 999);
        m_pre = 0;
        m_exp = 0;
      end else begin
        if (bus.enable) m_pre = fire ? 0 : m_pre + 1;
        if (fire) begin
          m_tick = 1;
          if (!bus.mode) begin
            if (m_tot == MAXT - 1) begin m_tot = 0; m_wrap = 1; end
            else m_tot++;
          end else if (!m_exp) begin
            if (m_tot == 0) m_exp = 1;
            else m_tot--;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("time", {bus.hr, bus.min, bus.s, bus.ms}, enc_tot(m_tot));
    chk("flags", {bus.tick, bus.wrap, bus.expired, bus.lap_valid},
        {m_tick, m_wrap, m_exp, m_lapv});
    chk("lap", {bus.lap_hr, bus.lap_min, bus.lap_s, bus.lap_ms}, enc_tot(m_lap));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(int h, int mi, int s, int ms);
    bus.load = 1'b1;
    bus.load_hr = HW'(h); bus.load_min = 6'(mi); bus.load_s = 6'(s); bus.load_ms = 10'(ms);
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin cyc(); n++; end while (!bus.tick && n < 20);
    chk("tick_seen", {63'd0, bus.tick}, 64'd1);
  endtask

  logic [25:0] now_t;
  assign now_t = {bus.hr, bus.min, bus.s, bus.ms};

  initial begin
    int n;
    reset = 1'b1;
    bus.enable = 1'b1; bus.mode = 1'b0; bus.load = 1'b0; bus.lap = 1'b0;
    bus.load_ms = '0; bus.load_s = '0; bus.load_min = '0; bus.load_hr = '0;

    // 1: reset with enable high, then first tick latency
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_tick", {63'd0, bus.tick}, 64'd0);
    end
    chk("rst_time", now_t, 26'd0);
    reset = 1'b0;
    wait_tick(n);
    chk("first_tick_lat", n, 4);

    // 2: 1100 up ticks, then freeze and resume
    run(4396);
    chk("t1100", now_t, enc(0, 0, 1, 100));
    run(2);
    bus.enable = 1'b0;
    run(10);
    chk("frozen", now_t, enc(0, 0, 1, 100));
    bus.enable = 1'b1;
    wait_tick(n);
    chk("resume_lat", n, 2);
    chk("resume_val", now_t, enc(0, 0, 1, 101));

    // 3: carries and full wrap
    do_load(1, 59, 59, 999);
    wait_tick(n);
    chk("carry_hr", now_t, enc(2, 0, 0, 0));
    do_load(9, 59, 59, 999);
    wait_tick(n);
    chk("wrap_val", now_t, 26'd0);
    chk("wrap_pulse", {63'd0, bus.wrap}, 64'd1);
    cyc();
    chk("wrap_end", {63'd0, bus.wrap}, 64'd0);

    // 4: count down, borrow, expiry
    bus.mode = 1'b1;
    do_load(0, 2, 3, 548);
    run(548 * TD);
    chk("down548", now_t, enc(0, 2, 3, 0));
    wait_tick(n);
    chk("borrow", now_t, enc(0, 2, 2, 999));
    do_load(0, 0, 0, 2);
    run(2 * TD);
    chk("down_zero", now_t, 26'd0);
    chk("not_exp", {63'd0, bus.expired}, 64'd0);
    wait_tick(n);
    chk("expired", {63'd0, bus.expired}, 64'd1);
    chk("exp_hold", now_t, 26'd0);
    run(TD);
    chk("exp_hold2", now_t, 26'd0);
    do_load(0, 0, 0, 2);
    chk("exp_clr", {63'd0, bus.expired}, 64'd0);

    // 5: lap coinciding with a tick; load coinciding with a tick
    bus.mode = 1'b0;
    do_load(0, 0, 0, 4);
    wait_tick(n);
    run(TD - 1);
    bus.lap = 1'b1;
    cyc();
    bus.lap = 1'b0;
    chk("lap_pre", {bus.lap_hr, bus.lap_min, bus.lap_s, bus.lap_ms}, enc(0, 0, 0, 5));
    chk("lap_tickval", now_t, enc(0, 0, 0, 6));
    chk("lap_valid", {63'd0, bus.lap_valid}, 64'd1);
    cyc();
    chk("lap_valid_end", {63'd0, bus.lap_valid}, 64'd0);
    run(TD - 2);
    do_load(0, 0, 30, 0);
    chk("load_on_tick", now_t, enc(0, 0, 30, 0));
    chk("tick_dropped", {63'd0, bus.tick}, 64'd0);

    // 6: saturated preset, then reset racing load and lap
    do_load(15, 60, 63, 1023);
    chk("sat", now_t, enc(9, 59, 59, 999));
    run(5);
    reset = 1'b1; bus.load = 1'b1; bus.lap = 1'b1;
    cyc();
    reset = 1'b0; bus.load = 1'b0; bus.lap = 1'b0;
    chk("rst_ovr_time", now_t, 26'd0);
    chk("rst_ovr_lapv", {63'd0, bus.lap_valid}, 64'd0);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 63) == 0) bus.mode = ~bus.mode;
      bus.lap    = ($urandom_range(0, 19) == 0);
      bus.load   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) begin
        bus.load_hr = '0; bus.load_min = '0; bus.load_s = '0;
        bus.load_ms = 10'($urandom_range(0, 6));
      end else begin
        bus.load_hr  = HW'($urandom);
        bus.load_min = 6'($urandom);
        bus.load_s   = 6'($urandom);
        bus.load_ms  = 10'($urandom);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watch_counter.md
Name: watch_counter

Overview:
- Sequential time base for the stopwatch datapath. Divides the system clock into 1 ms ticks and keeps hr:min:s:ms directly in cascaded field counters, so no binary-count-to-fields conversion is needed downstream.
- Parametrised successor of the combinational count-to-watch converter.
- Adds count-up (stopwatch) and count-down (timer) modes, preset load, lap capture, and wrap and expiry flags.
- Outputs drive the display formatter.

Parameters:
- TICK_DIV, 50000, system clock cycles per 1 ms tick (>=2; 50 MHz clock).
- HR_WIDTH, 4, width of the hour field.
- HR_LIMIT, 10, hour modulus; hr runs 0..HR_LIMIT-1 (must be <= 2**HR_WIDTH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; highest priority
- enable  in  1  1 = prescaler and counters run; 0 = freeze
- mode  in  1  0 = count up, 1 = count down
- load  in  1  1-cycle strobe; preset fields from load_* inputs
- load_ms  in  10  preset milliseconds
- load_s  in  6  preset seconds
- load_min  in  6  preset minutes
- load_hr  in  HR_WIDTH  preset hours
- lap  in  1  1-cycle strobe; capture current time
- ms  out  10  0..999
- s  out  6  0..59
- min  out  6  0..59
- hr  out  HR_WIDTH  0..HR_LIMIT-1
- lap_ms / lap_s / lap_min / lap_hr  out  10/6/6/HR_WIDTH  captured time
- lap_valid  out  1  1-cycle pulse, cycle after capture
- tick  out  1  1-cycle strobe when the 1 ms tick fires
- wrap  out  1  1-cycle pulse when count up rolls over from HR_LIMIT-1:59:59:999 to zero
- expired  out  1  sticky; count down reached zero

Behaviour:
- Reset:
  - All fields, lap fields, prescaler, tick, wrap, lap_valid and expired are 0.
  - Reset overrides load, lap and enable in the same cycle.
- Priority per cycle: reset > load > tick update. Lap capture is independent.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while enable=1; holds its value while enable=0 (not cleared).
  - The tick fires on the cycle the prescaler equals TICK_DIV-1 and enable=1. The prescaler returns to 0 and the fields update on that same edge. The tick output is registered (visible the following cycle, aligned with the new field values).
  - First tick after reset+enable: TICK_DIV cycles.
- Count up (mode=0), on tick:
  - ms+1; 999→0 carries into s.
  - s 59→0 carries into min; min 59→0 carries into hr.
  - hr HR_LIMIT-1→0 wraps all fields to 0 and pulses wrap.
- Count down (mode=1), on tick:
  - ms-1; 0→999 borrows from s, and likewise up the chain.
  - When all fields are 0 at a tick, the fields hold at 0 and expired sets.
  - expired stays set until reset or load; while it is set, down ticks do nothing.
  - Switching to mode=0 while expired: counting resumes upward and expired stays set.
- mode is sampled only at the tick, so a change takes effect on the next tick. mode never alters current values.
- Load:
  - Next cycle the fields equal the load values, saturated per field (ms>999→999, s/min>59→59, hr>=HR_LIMIT→HR_LIMIT-1).
  - Load also clears the prescaler and expired.
  - A tick coinciding with load is discarded.
- Lap:
  - Captures the field values present in the cycle lap is asserted, i.e. pre-update values if a tick or load occurs that cycle.
  - lap_valid pulses the next cycle.
  - Lap fields hold until the next lap or reset. Lap works with enable=0.
- No combinational input-to-output paths.

Decomposition:
- Shared package watch_pkg holds:
  - constants MS_MAX=999, SEC_MAX=59, MIN_MAX=59;
  - field widths 10/6/6;
  - a time-of-day struct type {hr, min, s, ms} used by the display formatter and the count-to-watch converter.
- One sub-module is natural: watch_digit_cnt, a parametrised modulus up/down counter with inc, dec, load and carry/borrow out. It is instantiated four times and chained.

Test Plan (TICK_DIV=4, HR_LIMIT=10):
1. Reset held 3 cycles with enable=1 → all outputs 0; no tick during reset; first tick 4 cycles after release.
2. enable=1, mode=0 for 1100 ticks (4400 cycles) → hr:min:s:ms = 0:00:01:100. Drop enable for 10 cycles → values and prescaler frozen; re-enable → next tick after the remaining cycles.
3. Load 1:59:59:999, one up tick → 2:00:00:000. Load 9:59:59:999, one tick → 0:00:00:000 with a 1-cycle wrap pulse.
4. Load 0:02:03:548, mode=1, 548 ticks → 0:02:03:000; one more tick → 0:02:02:999. Load 0:00:00:002 → after 2 ticks fields are 0; third tick → expired=1, fields stay 0; load clears expired.
5. Same-cycle events: lap with a tick at 0:00:00:005 (up) → lap fields 0:00:00:005, fields 0:00:00:006, lap_valid next cycle. Load 0:00:30:000 on a tick cycle → fields 0:00:30:000, tick discarded.
6. Load out-of-range ms=1023, s=63, min=60, hr=15 → fields 9:59:59:999. Reset asserted mid-count concurrently with load and lap → all outputs 0, no lap_valid.
